ofm_writeback: RTL and testbench



---
 rtl/ofm_wb_pkg.sv | 17 +
 rtl/ofm_wb_if.sv | 13 +
 rtl/ofm_wb_addr_gen.sv | 49 ++++
 rtl/ofm_writeback.sv | 124 ++++++++++++
 tb/tb_ofm_writeback.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_wb_pkg.sv
// Shared types and width helpers for the ofm_writeback drain block.
package ofm_wb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      DONE
   } state_t;

   localparam int CHK_W = 32;

   // Counter width for a modulus n; a 1-entry count still needs one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ofm_wb_if.sv
// Feature-map RAM write port: request, address and data out, ready back.
interface ofm_wb_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_ready;

   modport master (output wr_en, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ofm_wb_addr_gen.sv
// Pixel/channel counters and running HWC write address for ofm_writeback.
module ofm_wb_addr_gen
   import ofm_wb_pkg::*;
#(
   parameter int DSP_NO    = 256,
   parameter int OUT_PIX   = 169,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0,
   localparam int CH_W     = cnt_w(DSP_NO),
   localparam int PIX_W    = cnt_w(OUT_PIX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [CH_W-1:0]   ch,
   output logic [ADDR_W-1:0] addr,
   output logic              last_ch,
   output logic              last_pix
);

   logic [PIX_W-1:0] pix;

   // Pixel-major layout makes the next address always addr+1, so no multiplier.
   // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch   <= '0;
         pix  <= '0;
         addr <= ADDR_W'(BASE_ADDR);
      end else if (clear) begin
         ch   <= '0;
         pix  <= '0;
         addr <= ADDR_W'(BASE_ADDR);
      end else if (advance) begin
         addr <= addr + ADDR_W'(1);
         if (last_ch) begin
            ch  <= '0;
            pix <= pix + PIX_W'(1);
         end else begin
            ch <= ch + CH_W'(1);
         end
      end
   end

   assign last_ch  = (ch == CH_W'(DSP_NO - 1));
   assign last_pix = (pix == PIX_W'(OUT_PIX - 1));

endmodule

// File: rtl/ofm_writeback.sv
// Captures one DSP_NO-wide ofm vector per pixel and drains it word-by-word to RAM.
// Optional running checksum of written words: define OFM_WB_CHECKSUM_EN.
module ofm_writeback
   import ofm_wb_pkg::*;
#(
   parameter int DSP_NO    = 256,
   parameter int WIDTH     = 16,
   parameter int OUT_PIX   = 169,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             layer_start,
   input  logic             ofm_valid,
   input  logic [WIDTH-1:0] ofm [DSP_NO],
   ofm_wb_if.master         wr,
   output logic             busy,
   output logic             overflow_err,
   output logic             layer_done,
   output logic [CHK_W-1:0] checksum
);

   localparam int CH_W = cnt_w(DSP_NO);

   state_t            state;
   logic [WIDTH-1:0]  shadow [DSP_NO];
   logic [CH_W-1:0]   ch;
   logic [CH_W-1:0]   ch_nxt;
   logic [ADDR_W-1:0] addr;
   logic              last_ch;
   logic              last_pix;
   logic              load;
   logic              advance;

   // layer_start outranks everything, including a coincident ofm_valid.
   assign load    = (state == IDLE) && ofm_valid && !layer_start;
   assign advance = (state == DRAIN) && wr.wr_en && wr.wr_ready && !layer_start;
   assign ch_nxt  = ch + CH_W'(1);

   ofm_wb_addr_gen #(
      .DSP_NO    (DSP_NO),
      .OUT_PIX   (OUT_PIX),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (layer_start),
      .advance  (advance),
      .ch       (ch),
      .addr     (addr),
      .last_ch  (last_ch),
      .last_pix (last_pix)
   );

   assign wr.wr_addr = addr;

   // NOTE: the shadow buffer is plain storage without reset; busy gates every read of it.
   always_ff @(posedge clk) begin
      if (load) shadow <= ofm;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wr.wr_en     <= 1'b0;
         wr.wr_data   <= '0;
         busy         <= 1'b0;
         overflow_err <= 1'b0;
         layer_done   <= 1'b0;
      end else if (layer_start) begin
         state        <= IDLE;
         wr.wr_en     <= 1'b0;
         wr.wr_data   <= '0;
         busy         <= 1'b0;
         overflow_err <= 1'b0;
         layer_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ofm_valid) begin
                  wr.wr_en   <= 1'b1;
                  wr.wr_data <= ofm[0];
                  busy       <= 1'b1;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (ofm_valid) overflow_err <= 1'b1;
               if (wr.wr_ready) begin
                  if (last_ch) begin
                     wr.wr_en <= 1'b0;
                     busy     <= 1'b0;
                     if (last_pix) begin
                        layer_done <= 1'b1;
                        state      <= DONE;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     wr.wr_data <= shadow[ch_nxt];
                  end
               end
            end
            DONE: begin
               if (ofm_valid) overflow_err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef OFM_WB_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              checksum <= '0;
      else if (layer_start) checksum <= '0;
      else if (advance)     checksum <= checksum + CHK_W'(wr.wr_data);
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback (DSP_NO=4, OUT_PIX=3, BASE_ADDR=0x100) with a queue-based reference model.
module tb_ofm_writeback;

   localparam int DSP_NO    = 4;
   localparam int WIDTH     = 16;
   localparam int OUT_PIX   = 3;
   localparam int ADDR_W    = 16;
   localparam int BASE_ADDR = 'h100;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
   } wr_t;

   logic             clk;
   logic             rst;
   logic             layer_start;
   logic             ofm_valid;
   logic [WIDTH-1:0] ofm [DSP_NO];
   logic             wr_ready;
   logic             busy;
   logic             overflow_err;
   logic             layer_done;
   logic [31:0]      checksum;

   ofm_wb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) wb ();
   assign wb.wr_ready = wr_ready;

   ofm_writeback #(
      .DSP_NO    (DSP_NO),
      .WIDTH     (WIDTH),
      .OUT_PIX   (OUT_PIX),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .layer_start  (layer_start),
      .ofm_valid    (ofm_valid),
      .ofm          (ofm),
      .wr           (wb.master),
      .busy         (busy),
      .overflow_err (overflow_err),
      .layer_done   (layer_done),
      .checksum     (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: a vector accepted while idle becomes DSP_NO pending writes.
   wr_t         exp_q [$];
   int          m_pix;
   bit          m_ovf;
   bit          m_done;
   logic [31:0] m_sum;

   always @(posedge clk or posedge rst) begin
      bit busy_pre, done_pre;
      if (rst || layer_start) begin
         exp_q.delete();
         m_pix  = 0;
         m_ovf  = 1'b0;
         m_done = 1'b0;
         m_sum  = '0;
      end else begin
         busy_pre = (exp_q.size() != 0);
         done_pre = m_done;
         if (busy_pre && wr_ready) begin
            m_sum = m_sum + 32'(exp_q[0].data);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               m_pix++;
               if (m_pix == OUT_PIX) m_done = 1'b1;
            end
         end
         if (ofm_valid) begin
            if (busy_pre || done_pre) m_ovf = 1'b1;
            else begin
               for (int i = 0; i < DSP_NO; i++) begin
                  wr_t w;
                  w.addr = ADDR_W'(BASE_ADDR + m_pix * DSP_NO + i);
                  w.data = ofm[i];
                  exp_q.push_back(w);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] chk_exp;
      if (!rst && mon_en) begin
`ifdef OFM_WB_CHECKSUM_EN
         chk_exp = m_sum;
`else
         chk_exp = '0;
`endif
         check("mon_wr_en", wb.wr_en, exp_q.size() != 0);
         check("mon_busy", busy, exp_q.size() != 0);
         check("mon_overflow", overflow_err, m_ovf);
         check("mon_layer_done", layer_done, m_done);
         check("mon_checksum", checksum, chk_exp);
         if (wb.wr_en && exp_q.size() != 0) begin
            check("mon_wr_addr", wb.wr_addr, exp_q[0].addr);
            check("mon_wr_data", wb.wr_data, exp_q[0].data);
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 layer_start = 1'b1;
      @(posedge clk); #1 layer_start = 1'b0;
   endtask

   // Returns one time unit after the edge that samples the strobe.
   task automatic send(input logic [WIDTH-1:0] d0, d1, d2, d3);
      @(posedge clk); #1;
      ofm[0] = d0; ofm[1] = d1; ofm[2] = d2; ofm[3] = d3;
      ofm_valid = 1'b1;
      @(posedge clk); #1 ofm_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wr_en"}, wb.wr_en, 1'b0);
      check({tag, "_wr_addr"}, wb.wr_addr, 16'h0100);
      check({tag, "_wr_data"}, wb.wr_data, 16'h0000);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_overflow"}, overflow_err, 1'b0);
      check({tag, "_layer_done"}, layer_done, 1'b0);
      check({tag, "_checksum"}, checksum, 32'd0);
   endtask

   initial begin
      rst = 1'b1; layer_start = 1'b0; ofm_valid = 1'b0; wr_ready = 1'b1;
      for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check_reset_values("reset");

      // Basic drain: four consecutive writes, busy falls after the last.
      pulse_start();
      send(16'd1, 16'd2, 16'd3, 16'd4);
      for (int k = 0; k < DSP_NO; k++) begin
         @(negedge clk);
         check("basic_wr_en", wb.wr_en, 1'b1);
         check("basic_wr_addr", wb.wr_addr, 32'h100 + 32'(k));
         check("basic_wr_data", wb.wr_data, 32'(k + 1));
      end
      @(negedge clk);
      check("basic_busy_drop", busy, 1'b0);

      // Full layer: two more vectors, done after the 12th write.
      repeat (5) @(negedge clk);
      send(16'h11, 16'h12, 16'h13, 16'h14);
      repeat (10) @(negedge clk);
      send(16'h21, 16'h22, 16'h23, 16'h24);
      repeat (5) @(negedge clk);
      check("full_layer_done", layer_done, 1'b1);
      check("full_wr_en_idle", wb.wr_en, 1'b0);
`ifdef OFM_WB_CHECKSUM_EN
      check("full_checksum", checksum, 32'd222);
`else
      check("full_checksum", checksum, 32'd0);
`endif
      send(16'd9, 16'd9, 16'd9, 16'd9);
      @(negedge clk);
      check("done_overflow", overflow_err, 1'b1);
      check("done_holds", layer_done, 1'b1);

      // Backpressure at ch=2.
      pulse_start();
      @(negedge clk);
      check("restart_done_clr", layer_done, 1'b0);
      check("restart_ovf_clr", overflow_err, 1'b0);
      send(16'h0A, 16'h0B, 16'h0C, 16'h0D);
      @(posedge clk);
      @(posedge clk); #1 wr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_addr", wb.wr_addr, 16'h0102);
         check("bp_hold_data", wb.wr_data, 16'h000C);
      end
      @(posedge clk); #1 wr_ready = 1'b1;
      @(negedge clk);
      check("bp_hold_addr_last", wb.wr_addr, 16'h0102);
      @(negedge clk);
      check("bp_ch3_addr", wb.wr_addr, 16'h0103);
      check("bp_ch3_busy", busy, 1'b1);
      @(negedge clk);
      check("bp_late_busy_drop", busy, 1'b0);

      // Overflow during drain of pixel 1; the dropped vector must not leak.
      send(16'h50, 16'h51, 16'h52, 16'h53);
      @(posedge clk);
      @(posedge clk); #1;
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'hEE;
      ofm_valid = 1'b1;
      @(posedge clk); #1 ofm_valid = 1'b0;
      @(negedge clk);
      check("ovf_set", overflow_err, 1'b1);
      check("ovf_orig_addr", wb.wr_addr, 16'h0107);
      check("ovf_orig_data", wb.wr_data, 16'h0053);
      @(negedge clk);
      check("ovf_sticky", overflow_err, 1'b1);
      send(16'h60, 16'h61, 16'h62, 16'h63);
      @(negedge clk);
      check("ovf_next_addr", wb.wr_addr, 16'h0108);
      check("ovf_next_data", wb.wr_data, 16'h0060);
      repeat (4) @(negedge clk);
      check("ovf_layer_done", layer_done, 1'b1);

      // layer_start together with ofm_valid: vector dropped, no overflow.
      pulse_start();
      @(posedge clk); #1 layer_start = 1'b1; ofm_valid = 1'b1;
      @(posedge clk); #1 layer_start = 1'b0; ofm_valid = 1'b0;
      @(negedge clk);
      check("start_wins_en", wb.wr_en, 1'b0);
      check("start_wins_ovf", overflow_err, 1'b0);

      // Abort at ch=1 of pixel 1.
      send(16'd1, 16'd1, 16'd1, 16'd1);
      repeat (5) @(negedge clk);
      send(16'd5, 16'd6, 16'd7, 16'd8);
      ofm_valid = 1'b1;
      @(posedge clk); #1 ofm_valid = 1'b0; layer_start = 1'b1;
      @(negedge clk);
      check("abort_pre_addr", wb.wr_addr, 16'h0105);
      check("abort_pre_ovf", overflow_err, 1'b1);
      @(posedge clk); #1 layer_start = 1'b0;
      @(negedge clk);
      check("abort_wr_en", wb.wr_en, 1'b0);
      check("abort_ovf_clr", overflow_err, 1'b0);
      check("abort_checksum", checksum, 32'd0);
      send(16'h70, 16'h71, 16'h72, 16'h73);
      @(negedge clk);
      check("abort_restart_addr", wb.wr_addr, 16'h0100);
      check("abort_restart_data", wb.wr_data, 16'h0070);

      // Asynchronous reset mid-drain.
      @(posedge clk); #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      #4 rst = 1'b0;
      @(negedge clk);
      check("async_idle_en", wb.wr_en, 1'b0);
      send(16'h80, 16'h81, 16'h82, 16'h83);
      @(negedge clk);
      check("async_restart_addr", wb.wr_addr, 16'h0100);
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
